// File: rtl/square_crop.sv
// square_crop: trims each frame to a centred square of side min(rows, cols)
// ahead of the circular crop stage. Frame dimensions are measured
// continuously and applied one frame later. One cycle of fixed latency, no
// backpressure.
// Optional build macro SQUARE_CROP_BLANK_EN: out-of-window beats are kept
// (dvo follows dvi) and out-of-window pixels are zeroed, so the original
// frame geometry is preserved.
`timescale 1ns/1ps

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        5
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK   5'b00001
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START  5'b00010
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END    5'b00011
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START    5'b00100
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END      5'b00101
`endif

module square_crop #(
  parameter int PIXEL_WIDTH = 10,
  parameter int DIM_WIDTH   = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    dvi,
  input  logic [PIXEL_WIDTH-1:0]  r,
  input  logic [PIXEL_WIDTH-1:0]  g,
  input  logic [PIXEL_WIDTH-1:0]  b,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [15:0]             meta_datai,
  output logic                    dvo,
  output logic [PIXEL_WIDTH-1:0]  ro,
  output logic [PIXEL_WIDTH-1:0]  go,
  output logic [PIXEL_WIDTH-1:0]  bo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]             meta_datao,
  output logic [DIM_WIDTH-1:0]    side,
  output logic                    active
);

  localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

  // Running counters and the last completed measurement
  logic [DIM_WIDTH-1:0] r_col;
  logic [DIM_WIDTH-1:0] r_row;
  logic [DIM_WIDTH-1:0] r_meas_cols;
  logic [DIM_WIDTH-1:0] r_meas_rows;
  logic                 r_dims_valid;

  // Per-frame crop geometry, latched at FRAME_START
  logic                 r_active;
  logic [DIM_WIDTH-1:0] r_sq;
  logic [DIM_WIDTH-1:0] r_col_off;
  logic [DIM_WIDTH-1:0] r_row_off;
  logic [DIM_WIDTH-1:0] r_side;

  // Output registers
  logic                    r_dvo;
  logic [PIXEL_WIDTH-1:0]  r_ro;
  logic [PIXEL_WIDTH-1:0]  r_go;
  logic [PIXEL_WIDTH-1:0]  r_bo;
  logic [`DTYPE_WIDTH-1:0] r_dtypeo;
  logic [15:0]             r_meta_datao;

  // Beat classification (valid beats only)
  logic w_is_pixel;
  logic w_is_fs;
  logic w_is_fe;
  logic w_is_re;
  logic w_pixel_beat;
  logic w_fs_beat;
  logic w_fe_beat;
  logic w_re_beat;

  // Geometry for the next frame, from the last completed measurement
  logic                 w_meas_ok;
  logic [DIM_WIDTH-1:0] w_sq;
  logic [DIM_WIDTH-1:0] w_col_off;
  logic [DIM_WIDTH-1:0] w_row_off;

  // Window test for the current beat
  logic [DIM_WIDTH:0]   w_row_lim;
  logic [DIM_WIDTH:0]   w_col_lim;
  logic                 w_in_row;
  logic                 w_in_col;
  logic                 w_out_win;

  assign w_is_pixel   = (dtypei == `DTYPE_PIXEL_MASK);
  assign w_is_fs      = (dtypei == `DTYPE_FRAME_START);
  assign w_is_fe      = (dtypei == `DTYPE_FRAME_END);
  assign w_is_re      = (dtypei == `DTYPE_ROW_END);
  assign w_pixel_beat = dvi && w_is_pixel;
  assign w_fs_beat    = dvi && w_is_fs;
  assign w_fe_beat    = dvi && w_is_fe;
  assign w_re_beat    = dvi && w_is_re;

  // Next-frame square and centring offsets (odd differences round down)
  always_comb begin
    w_meas_ok = enable && r_dims_valid && (r_meas_rows != '0) && (r_meas_cols != '0);
    w_sq      = (r_meas_rows < r_meas_cols) ? r_meas_rows : r_meas_cols;
    w_col_off = (r_meas_cols - w_sq) >> 1;
    w_row_off = (r_meas_rows - w_sq) >> 1;
  end

  // Window membership of the current beat using pre-increment row/col
  always_comb begin
    w_row_lim = {1'b0, r_row_off} + {1'b0, r_sq};
    w_col_lim = {1'b0, r_col_off} + {1'b0, r_sq};
    w_in_row  = (r_row >= r_row_off) && ({1'b0, r_row} < w_row_lim);
    w_in_col  = (r_col >= r_col_off) && ({1'b0, r_col} < w_col_lim);
    w_out_win = 1'b0;
    if (r_active) begin
      case (dtypei)
        `DTYPE_ROW_START,
        `DTYPE_ROW_END:    w_out_win = !w_in_row;
        `DTYPE_PIXEL_MASK: w_out_win = !(w_in_row && w_in_col);
        default:           w_out_win = 1'b0;
      endcase
    end
  end

  // Column counter: counts pixels within a row, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
    end else if (w_re_beat || w_fs_beat) begin
      r_col <= '0;
    end else if (w_pixel_beat && (r_col != '1)) begin
      r_col <= r_col + DIM_ONE;
    end
  end

  // Row counter: counts ROW_END tokens within a frame, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row <= '0;
    end else if (w_fs_beat) begin
      r_row <= '0;
    end else if (w_re_beat && (r_row != '1)) begin
      r_row <= r_row + DIM_ONE;
    end
  end

  // Measured dimensions; rows only commit on a completed frame, so a
  // truncated frame leaves the previous measurement in place
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meas_cols  <= '0;
      r_meas_rows  <= '0;
      r_dims_valid <= 1'b0;
    end else begin
      if (w_re_beat) begin
        r_meas_cols <= r_col;
      end
      if (w_fe_beat) begin
        r_meas_rows  <= r_row;
        r_dims_valid <= 1'b1;
      end
    end
  end

  // Frame latch: enable and geometry are sampled only at FRAME_START
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active  <= 1'b0;
      r_sq      <= '0;
      r_col_off <= '0;
      r_row_off <= '0;
      r_side    <= '0;
    end else if (w_fs_beat) begin
      r_active  <= w_meas_ok;
      r_sq      <= w_sq;
      r_col_off <= w_col_off;
      r_row_off <= w_row_off;
      r_side    <= w_meas_ok ? w_sq : '0;
    end
  end

  // Output stage: register every input; drop or blank out-of-window beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dvo        <= 1'b0;
      r_ro         <= '0;
      r_go         <= '0;
      r_bo         <= '0;
      r_dtypeo     <= '0;
      r_meta_datao <= '0;
    end else begin
      r_dtypeo     <= dtypei;
      r_meta_datao <= meta_datai;
`ifdef SQUARE_CROP_BLANK_EN
      r_dvo <= dvi;
      if (w_is_pixel && w_out_win) begin
        r_ro <= '0;
        r_go <= '0;
        r_bo <= '0;
      end else begin
        r_ro <= r;
        r_go <= g;
        r_bo <= b;
      end
`else
      r_dvo <= dvi && !w_out_win;
      r_ro  <= r;
      r_go  <= g;
      r_bo  <= b;
`endif
    end
  end

  assign dvo        = r_dvo;
  assign ro         = r_ro;
  assign go         = r_go;
  assign bo         = r_bo;
  assign dtypeo     = r_dtypeo;
  assign meta_datao = r_meta_datao;
  assign side       = r_side;
  assign active     = r_active;

endmodule

// File: tb/tb_square_crop.sv
// tb_square_crop: directed vector bench for square_crop. Frames are built
// into a vector table with hand-chosen keep windows, then replayed and
// compared one cycle after each beat.
`timescale 1ns/1ps

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        5
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK   5'b00001
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START  5'b00010
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END    5'b00011
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START    5'b00100
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END      5'b00101
`endif

module tb_square_crop;

  localparam logic [4:0] DT_PIX   = `DTYPE_PIXEL_MASK;
  localparam logic [4:0] DT_FS    = `DTYPE_FRAME_START;
  localparam logic [4:0] DT_FE    = `DTYPE_FRAME_END;
  localparam logic [4:0] DT_RS    = `DTYPE_ROW_START;
  localparam logic [4:0] DT_RE    = `DTYPE_ROW_END;
  localparam logic [4:0] DT_OTHER = 5'b01000;

`ifdef SQUARE_CROP_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        dvi;
  logic [9:0]  r, g, b;
  logic [4:0]  dtypei;
  logic [15:0] meta_datai;
  logic        dvo;
  logic [9:0]  ro, go, bo;
  logic [4:0]  dtypeo;
  logic [15:0] meta_datao;
  logic [11:0] side;
  logic        active;

  square_crop #(.PIXEL_WIDTH(10), .DIM_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dvi(dvi),
    .r(r), .g(g), .b(b), .dtypei(dtypei), .meta_datai(meta_datai),
    .dvo(dvo), .ro(ro), .go(go), .bo(bo), .dtypeo(dtypeo),
    .meta_datao(meta_datao), .side(side), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dvi;
    logic [4:0]  dt;
    logic [9:0]  px;
    logic [15:0] md;
    logic        en;
    logic        keep;
    logic        act;
    logic [11:0] sd;
  } vec_t;

  vec_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec_no = 0;

  task automatic chk(input string nm, input int idx, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, a, e);
    end
  endtask

  function automatic void push(input logic v, input logic [4:0] dt, input logic [9:0] px,
                               input logic en, input logic keep, input logic act,
                               input logic [11:0] sd);
    vec_t x;
    x.dvi  = v;
    x.dt   = dt;
    x.px   = px;
    x.md   = 16'(vec_no) ^ 16'hA5A5;
    x.en   = en;
    x.keep = keep;
    x.act  = act;
    x.sd   = sd;
    vec_no++;
    q.push_back(x);
  endfunction

  // One frame; keep window rows [r0,r1), cols [c0,c1) applies when act=1.
  // Enable switches from en_a to en_b halfway through the rows.
  function automatic void add_frame(input int cols, input int rows, input logic en_a,
                                    input logic en_b, input logic fe, input logic act,
                                    input int sd, input int r0, input int r1,
                                    input int c0, input int c1);
    logic       en;
    logic       rk;
    logic       ck;
    logic [4:0] rr;
    logic [4:0] cc;
    push(1'b1, DT_FS, 10'h3C0, en_a, 1'b1, act, 12'(sd));
    push(1'b1, DT_OTHER, 10'h2AA, en_a, 1'b1, act, 12'(sd));
    for (int row = 0; row < rows; row++) begin
      en = (row < rows / 2) ? en_a : en_b;
      rk = !act || (row >= r0 && row < r1);
      rr = 5'(row);
      push(1'b1, DT_RS, {rr, 5'h1E}, en, rk, act, 12'(sd));
      for (int col = 0; col < cols; col++) begin
        ck = !act || (col >= c0 && col < c1);
        cc = 5'(col);
        push(1'b1, DT_PIX, {rr, cc}, en, rk && ck, act, 12'(sd));
      end
      push(1'b1, DT_RE, {rr, 5'h1F}, en, rk, act, 12'(sd));
    end
    if (fe) push(1'b1, DT_FE, 10'h3C1, en_b, 1'b1, act, 12'(sd));
    push(1'b0, DT_PIX, 10'h155, en_b, 1'b1, act, 12'(sd));
  endfunction

  task automatic run_queue();
    logic        exp_dvo;
    logic [9:0]  er, eg, eb;
    for (int i = 0; i < q.size(); i++) begin
      enable     = q[i].en;
      dvi        = q[i].dvi;
      dtypei     = q[i].dt;
      r          = q[i].px;
      g          = q[i].px ^ 10'h155;
      b          = ~q[i].px;
      meta_datai = q[i].md;
      @(posedge clk);
      #1;
      exp_dvo = q[i].dvi && (BLANK || q[i].keep);
      chk("dvo", i, 64'(dvo), 64'(exp_dvo));
      if (exp_dvo) begin
        if (BLANK && !q[i].keep && q[i].dt == DT_PIX) begin
          er = '0; eg = '0; eb = '0;
        end else begin
          er = q[i].px; eg = q[i].px ^ 10'h155; eb = ~q[i].px;
        end
        chk("data", i, 64'({dtypeo, meta_datao, ro, go, bo}),
            64'({q[i].dt, q[i].md, er, eg, eb}));
      end
      chk("state", i, 64'({active, side}), 64'({q[i].act, q[i].sd}));
    end
    q.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_data"}, 0, 64'({dvo, ro, go, bo, dtypeo}), 64'd0);
    chk({nm, "_side"}, 0, 64'({meta_datao, side, active}), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dvi   = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; dvi = 1'b0; r = '0; g = '0; b = '0;
    dtypei = '0; meta_datai = '0;
    do_reset();

    // 8x4: pass-through, cropped with mid-frame disable, pass-through,
    // cropped, truncated, cropped using the last completed measurement
    add_frame(8, 4, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 4, 0, 8);
    add_frame(8, 4, 1'b1, 1'b0, 1'b1, 1'b1, 4, 0, 4, 2, 6);
    add_frame(8, 4, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 4, 0, 8);
    add_frame(8, 4, 1'b1, 1'b1, 1'b1, 1'b1, 4, 0, 4, 2, 6);
    add_frame(8, 2, 1'b1, 1'b1, 1'b0, 1'b1, 4, 0, 4, 2, 6);
    add_frame(8, 4, 1'b1, 1'b1, 1'b1, 1'b1, 4, 0, 4, 2, 6);
    run_queue();

    // 8x4 then 4x6: first 4x6 frame still uses the 8x4 geometry
    do_reset();
    add_frame(8, 4, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 4, 0, 8);
    add_frame(8, 4, 1'b1, 1'b1, 1'b1, 1'b1, 4, 0, 4, 2, 6);
    add_frame(4, 6, 1'b1, 1'b1, 1'b1, 1'b1, 4, 0, 4, 2, 6);
    add_frame(4, 6, 1'b1, 1'b1, 1'b1, 1'b1, 4, 1, 5, 0, 4);
    add_frame(4, 6, 1'b1, 1'b1, 1'b1, 1'b1, 4, 1, 5, 0, 4);
    run_queue();

    // 5x5 square, then 7x4 (odd difference: col offset 1)
    do_reset();
    add_frame(5, 5, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 5, 0, 5);
    add_frame(5, 5, 1'b1, 1'b1, 1'b1, 1'b1, 5, 0, 5, 0, 5);
    add_frame(7, 4, 1'b1, 1'b1, 1'b1, 1'b1, 5, 0, 5, 0, 5);
    add_frame(7, 4, 1'b1, 1'b1, 1'b1, 1'b1, 4, 0, 4, 1, 5);
    run_queue();

    // Reset in the middle of row 1 of the first cropped frame
    do_reset();
    add_frame(8, 4, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 4, 0, 8);
    add_frame(8, 1, 1'b1, 1'b1, 1'b0, 1'b1, 4, 0, 4, 2, 6);
    push(1'b1, DT_RS, 10'h03E, 1'b1, 1'b1, 1'b1, 12'd4);
    push(1'b1, DT_PIX, 10'h020, 1'b1, 1'b0, 1'b1, 12'd4);
    push(1'b1, DT_PIX, 10'h021, 1'b1, 1'b0, 1'b1, 12'd4);
    push(1'b1, DT_PIX, 10'h022, 1'b1, 1'b1, 1'b1, 12'd4);
    run_queue();
    #2;
    reset = 1'b1;
    #1;
    chk_zero("async_rst");
    dvi = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("held_rst");
    reset = 1'b0;
    add_frame(8, 4, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 4, 0, 8);
    add_frame(8, 4, 1'b1, 1'b1, 1'b1, 1'b1, 4, 0, 4, 2, 6);
    run_queue();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
